// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// MCU_BNE_EN adds the BNE state and makes opcode 000101 legal.
package mcu_pkg;

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExec   = 4'd6,
      StAluWb  = 4'd7,
      StAddiEx = 4'd8,
      StAddiWb = 4'd9,
      StBranch = 4'd10,
      StJump   = 4'd11
`ifdef MCU_BNE_EN
      ,
      StBne    = 4'd12
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_NOR = 6'b100111;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_NOR = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> IR/datapath bundle; master is the control unit, slave the datapath.
interface multicycle_control_unit_if #(
   parameter int unsigned OP_W      = 6,
   parameter int unsigned FUNCT_W   = 6,
   parameter int unsigned ALUCTRL_W = 3,
   parameter int unsigned STATE_W   = 4
);
   logic [OP_W-1:0]      op;
   logic [FUNCT_W-1:0]   funct;
   logic                 zero;
   logic                 mem_ready;
   logic                 pc_en;
   logic                 iord;
   logic                 ir_write;
   logic                 mem_write;
   logic                 reg_write;
   logic                 reg_dst;
   logic                 mem_to_reg;
   logic                 alu_src_a;
   logic [1:0]           alu_src_b;
   logic [1:0]           pc_src;
   logic [ALUCTRL_W-1:0] alu_control;
   logic                 illegal;
   logic [STATE_W-1:0]   state_o;

   modport master (
      input  op, funct, zero, mem_ready,
      output pc_en, iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, pc_src, alu_control, illegal, state_o
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  pc_en, iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg,
             alu_src_a, alu_src_b, pc_src, alu_control, illegal, state_o
   );

endinterface

// File: rtl/mcu_alu_decoder.sv
// R-type funct to ALU control decode, with a flag for supported funct codes.
module mcu_alu_decoder
   import mcu_pkg::*;
#(
   parameter int unsigned FUNCT_W   = 6,
   parameter int unsigned ALUCTRL_W = 3
) (
   input  logic [FUNCT_W-1:0]   funct_i,
   output logic [ALUCTRL_W-1:0] alu_control_o,
   output logic                 funct_valid_o
);

   always_comb begin
      alu_control_o = ALUCTRL_W'(ALU_ADD);
      funct_valid_o = 1'b1;
      case (funct_i)
         FUNCT_W'(F_ADD): alu_control_o = ALUCTRL_W'(ALU_ADD);
         FUNCT_W'(F_SUB): alu_control_o = ALUCTRL_W'(ALU_SUB);
         FUNCT_W'(F_AND): alu_control_o = ALUCTRL_W'(ALU_AND);
         FUNCT_W'(F_OR):  alu_control_o = ALUCTRL_W'(ALU_OR);
         FUNCT_W'(F_NOR): alu_control_o = ALUCTRL_W'(ALU_NOR);
         FUNCT_W'(F_SLT): alu_control_o = ALUCTRL_W'(ALU_SLT);
         default:         funct_valid_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: Moore decode of state, write enables gated by mem_ready/zero.
// Define MCU_BNE_EN to add BNE support.
module multicycle_control_unit
   import mcu_pkg::*;
#(
   parameter int unsigned OP_W      = 6,
   parameter int unsigned FUNCT_W   = 6,
   parameter int unsigned ALUCTRL_W = 3,
   parameter int unsigned STATE_W   = 4
) (
   input logic                       clk,
   input logic                       rst_n,
   multicycle_control_unit_if.master bus
);

   state_t               state_q, state_d;
   logic                 run_q;
   logic                 is_load_q, is_load_d;
   logic [ALUCTRL_W-1:0] funct_alu;
   logic                 funct_valid;
   logic                 op_legal;
   logic                 pc_write, branch, branch_ne;
   logic                 ir_write_raw, mem_write_raw, reg_write_raw;

   mcu_alu_decoder #(
      .FUNCT_W  (FUNCT_W),
      .ALUCTRL_W(ALUCTRL_W)
   ) u_alu_dec (
      .funct_i      (bus.funct),
      .alu_control_o(funct_alu),
      .funct_valid_o(funct_valid)
   );

   always_comb begin : next_state
      state_d   = state_q;
      is_load_d = is_load_q;
      op_legal  = 1'b1;
      unique case (state_q)
         // Hold in FETCH until the first edge after reset release has set run_q.
         StFetch:  if (run_q && bus.mem_ready) state_d = StDecode;
         StDecode: begin
            is_load_d = (bus.op == OP_W'(OP_LW));
            case (bus.op)
               OP_W'(OP_LW),
               OP_W'(OP_SW):    state_d = StMemAdr;
               OP_W'(OP_RTYPE): begin
                  state_d  = funct_valid ? StExec : StFetch;
                  op_legal = funct_valid;
               end
               OP_W'(OP_ADDI):  state_d = StAddiEx;
               OP_W'(OP_BEQ):   state_d = StBranch;
               OP_W'(OP_J):     state_d = StJump;
`ifdef MCU_BNE_EN
               OP_W'(OP_BNE):   state_d = StBne;
`endif
               default: begin
                  state_d  = StFetch;
                  op_legal = 1'b0;
               end
            endcase
         end
         StMemAdr: state_d = is_load_q ? StMemRd : StMemWr;
         StMemRd:  if (bus.mem_ready) state_d = StMemWb;
         StMemWr:  if (bus.mem_ready) state_d = StFetch;
         StExec:   state_d = StAluWb;
         StAddiEx: state_d = StAddiWb;
         default:  state_d = StFetch;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin : fsm
      if (!rst_n) begin
         state_q   <= StFetch;
         run_q     <= 1'b0;
         is_load_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_q     <= 1'b1;
         is_load_q <= is_load_d;
      end
   end

   always_comb begin : decode
      pc_write        = 1'b0;
      branch          = 1'b0;
      branch_ne       = 1'b0;
      ir_write_raw    = 1'b0;
      mem_write_raw   = 1'b0;
      reg_write_raw   = 1'b0;
      bus.iord        = 1'b0;
      bus.reg_dst     = 1'b0;
      bus.mem_to_reg  = 1'b0;
      bus.alu_src_a   = 1'b0;
      bus.alu_src_b   = SRCB_B;
      bus.pc_src      = PCSRC_ALU;
      bus.alu_control = ALUCTRL_W'(ALU_ADD);
      bus.illegal     = 1'b0;
      unique case (state_q)
         StFetch: begin
            bus.alu_src_b = SRCB_FOUR;
            ir_write_raw  = bus.mem_ready;
            pc_write      = bus.mem_ready;
         end
         StDecode: begin
            bus.alu_src_b = SRCB_IMM_SH;
            bus.illegal   = ~op_legal;
         end
         StMemAdr, StAddiEx: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = SRCB_IMM;
         end
         StMemRd: bus.iord = 1'b1;
         StMemWb: begin
            reg_write_raw  = 1'b1;
            bus.mem_to_reg = 1'b1;
         end
         StMemWr: begin
            bus.iord      = 1'b1;
            mem_write_raw = 1'b1;
         end
         StExec: begin
            bus.alu_src_a   = 1'b1;
            bus.alu_control = funct_alu;
         end
         StAluWb: begin
            reg_write_raw = 1'b1;
            bus.reg_dst   = 1'b1;
         end
         StAddiWb: reg_write_raw = 1'b1;
         StBranch: begin
            bus.alu_src_a   = 1'b1;
            bus.alu_control = ALUCTRL_W'(ALU_SUB);
            bus.pc_src      = PCSRC_ALUOUT;
            branch          = 1'b1;
         end
`ifdef MCU_BNE_EN
         StBne: begin
            bus.alu_src_a   = 1'b1;
            bus.alu_control = ALUCTRL_W'(ALU_SUB);
            bus.pc_src      = PCSRC_ALUOUT;
            branch_ne       = 1'b1;
         end
`endif
         StJump: begin
            bus.pc_src = PCSRC_JUMP;
            pc_write   = 1'b1;
         end
         default: ;
      endcase
   end

   // run_q keeps every write enable low during reset and the first cycle after release.
   assign bus.pc_en     = run_q & (pc_write | (branch & bus.zero) | (branch_ne & ~bus.zero));
   assign bus.ir_write  = run_q & ir_write_raw;
   assign bus.mem_write = run_q & mem_write_raw;
   assign bus.reg_write = run_q & reg_write_raw;
   assign bus.state_o   = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle state and write-enable sequences.
module tb_multicycle_control_unit;
   import mcu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail = 0;

   multicycle_control_unit_if #(.OP_W(6), .FUNCT_W(6), .ALUCTRL_W(3), .STATE_W(4)) bus ();

   multicycle_control_unit #(.OP_W(6), .FUNCT_W(6), .ALUCTRL_W(3), .STATE_W(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // {pc_en, ir_write, mem_write, reg_write, illegal}
   wire [4:0] wei = {bus.pc_en, bus.ir_write, bus.mem_write, bus.reg_write, bus.illegal};

   task automatic test_reset();
      rst_n = 1'b0;
      bus.mem_ready = 1'b1;
      bus.zero = 1'b0;
      bus.op = OP_RTYPE;
      bus.funct = F_ADD;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({bus.state_o, wei, bus.iord, bus.alu_src_b, bus.pc_src, bus.alu_control} !==
             {4'(StFetch), 5'b00000, 1'b0, 2'b01, 2'b00, 3'b010}) begin
            n_fail++;
            $display("FAIL reset_hold%0d: state=%0d we/ill=%b srcb=%b alu=%b, expected FETCH 00000 01 010",
                     i, bus.state_o, wei, bus.alu_src_b, bus.alu_control);
         end
      end
      #2 rst_n = 1'b1;
      #1;
      n_checks++;
      if (wei !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_first_cycle: we/ill=%b, expected 00000", wei);
      end
      @(posedge clk); #2;
      n_checks++;
      if (bus.state_o !== 4'(StFetch) || wei !== 5'b11000) begin
         n_fail++;
         $display("FAIL reset_run: state=%0d we/ill=%b, expected %0d 11000",
                  bus.state_o, wei, StFetch);
      end
      bus.mem_ready = 1'b0;
   endtask

   task automatic test_lw();
      state_t     st [6] = '{StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StFetch};
      logic       mr [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [4:0] ex [6] = '{5'b11000, 5'b0, 5'b0, 5'b0, 5'b00010, 5'b0};
      bus.op = OP_LW;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         bus.mem_ready = mr[i];
         #1;
         n_checks++;
         if (bus.state_o !== 4'(st[i]) || wei !== ex[i]) begin
            n_fail++;
            $display("FAIL lw_cyc%0d: state=%0d we/ill=%b, expected %0d %b",
                     i, bus.state_o, wei, st[i], ex[i]);
         end
         if (i == 3) begin
            n_checks++;
            if (bus.iord !== 1'b1) begin
               n_fail++;
               $display("FAIL lw_memrd_iord: got %b, expected 1", bus.iord);
            end
         end
         if (i == 4) begin
            n_checks++;
            if ({bus.mem_to_reg, bus.reg_dst} !== 2'b10) begin
               n_fail++;
               $display("FAIL lw_memwb_mux: mem_to_reg/reg_dst=%b%b, expected 10",
                        bus.mem_to_reg, bus.reg_dst);
            end
         end
      end
   endtask

   task automatic test_sw_stall();
      state_t     st [7] = '{StFetch, StDecode, StMemAdr, StMemWr, StMemWr, StMemWr, StFetch};
      logic       mr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [4:0] ex [7] = '{5'b11000, 5'b0, 5'b0, 5'b00100, 5'b00100, 5'b00100, 5'b0};
      bus.op = OP_SW;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         bus.mem_ready = mr[i];
         #1;
         n_checks++;
         if (bus.state_o !== 4'(st[i]) || wei !== ex[i] || (i >= 3 && i <= 5 && bus.iord !== 1'b1)) begin
            n_fail++;
            $display("FAIL sw_cyc%0d: state=%0d we/ill=%b iord=%b, expected %0d %b",
                     i, bus.state_o, wei, bus.iord, st[i], ex[i]);
         end
      end
   endtask

   task automatic test_branch(input logic [5:0] op, input logic z, input logic [4:0] ex_br);
      state_t     st [4] = '{StFetch, StDecode, StBranch, StFetch};
      logic       mr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [4:0] ex [4] = '{5'b11000, 5'b0, ex_br, 5'b0};
`ifdef MCU_BNE_EN
      if (op == OP_BNE) st[2] = StBne;
`endif
      bus.op = op;
      bus.zero = z;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         bus.mem_ready = mr[i];
         #1;
         n_checks++;
         if (bus.state_o !== 4'(st[i]) || wei !== ex[i]) begin
            n_fail++;
            $display("FAIL branch_op%b_z%b_cyc%0d: state=%0d we/ill=%b, expected %0d %b",
                     op, z, i, bus.state_o, wei, st[i], ex[i]);
         end
         if (i == 2) begin
            n_checks++;
            if ({bus.pc_src, bus.alu_control, bus.alu_src_a, bus.alu_src_b} !== 8'b01_110_1_00) begin
               n_fail++;
               $display("FAIL branch_mux: pcsrc/alu/srca/srcb=%b %b %b %b, expected 01 110 1 00",
                        bus.pc_src, bus.alu_control, bus.alu_src_a, bus.alu_src_b);
            end
         end
      end
      bus.zero = 1'b0;
   endtask

   task automatic test_jump();
      state_t     st [4] = '{StFetch, StDecode, StJump, StFetch};
      logic [4:0] ex [4] = '{5'b11000, 5'b0, 5'b10000, 5'b0};
      bus.op = OP_J;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         bus.mem_ready = (i != 3);
         #1;
         n_checks++;
         if (bus.state_o !== 4'(st[i]) || wei !== ex[i] || (i == 2 && bus.pc_src !== 2'b10)) begin
            n_fail++;
            $display("FAIL jump_cyc%0d: state=%0d we/ill=%b pcsrc=%b, expected %0d %b",
                     i, bus.state_o, wei, bus.pc_src, st[i], ex[i]);
         end
      end
   endtask

   task automatic test_rtype();
      state_t     st [5] = '{StFetch, StDecode, StExec, StAluWb, StFetch};
      logic [4:0] ex [5] = '{5'b11000, 5'b0, 5'b0, 5'b00010, 5'b0};
      bus.op = OP_RTYPE;
      bus.funct = F_SLT;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         bus.mem_ready = (i != 4);
         #1;
         n_checks++;
         if (bus.state_o !== 4'(st[i]) || wei !== ex[i]) begin
            n_fail++;
            $display("FAIL rtype_cyc%0d: state=%0d we/ill=%b, expected %0d %b",
                     i, bus.state_o, wei, st[i], ex[i]);
         end
         if (i == 2) begin
            n_checks++;
            if ({bus.alu_control, bus.alu_src_a, bus.alu_src_b} !== 6'b111_1_00) begin
               n_fail++;
               $display("FAIL rtype_exec: alu/srca/srcb=%b %b %b, expected 111 1 00",
                        bus.alu_control, bus.alu_src_a, bus.alu_src_b);
            end
         end
         if (i == 3) begin
            n_checks++;
            if ({bus.reg_dst, bus.mem_to_reg} !== 2'b10) begin
               n_fail++;
               $display("FAIL rtype_aluwb: reg_dst/mem_to_reg=%b%b, expected 10",
                        bus.reg_dst, bus.mem_to_reg);
            end
         end
      end
   endtask

   task automatic test_illegal(input logic [5:0] op, input logic [5:0] funct);
      state_t     st [3] = '{StFetch, StDecode, StFetch};
      logic [4:0] ex [3] = '{5'b11000, 5'b00001, 5'b0};
      bus.op = op;
      bus.funct = funct;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         bus.mem_ready = (i != 2);
         #1;
         n_checks++;
         if (bus.state_o !== 4'(st[i]) || wei !== ex[i]) begin
            n_fail++;
            $display("FAIL illegal_op%b_f%b_cyc%0d: state=%0d we/ill=%b, expected %0d %b",
                     op, funct, i, bus.state_o, wei, st[i], ex[i]);
         end
      end
   endtask

   task automatic test_reset_abort();
      bus.op = OP_LW;
      bus.mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.mem_ready = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (bus.state_o !== 4'(StMemRd)) begin
         n_fail++;
         $display("FAIL abort_setup: state=%0d, expected %0d", bus.state_o, StMemRd);
      end
      bus.mem_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.state_o !== 4'(StFetch) || wei !== 5'b0) begin
         n_fail++;
         $display("FAIL abort_async: state=%0d we/ill=%b, expected %0d 00000",
                  bus.state_o, wei, StFetch);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (bus.state_o !== 4'(StFetch) || wei !== 5'b11000) begin
         n_fail++;
         $display("FAIL abort_resume: state=%0d we/ill=%b, expected %0d 11000",
                  bus.state_o, wei, StFetch);
      end
      bus.mem_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_stall();
      test_branch(OP_BEQ, 1'b1, 5'b10000);
      test_branch(OP_BEQ, 1'b0, 5'b00000);
      test_jump();
      test_rtype();
      test_illegal(OP_RTYPE, 6'b000000);
`ifdef MCU_BNE_EN
      test_branch(OP_BNE, 1'b0, 5'b10000);
      test_branch(OP_BNE, 1'b1, 5'b00000);
`else
      test_illegal(OP_BNE, F_ADD);
`endif
      test_illegal(6'b111111, F_ADD);
      test_reset_abort();
      test_lw();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
